// File: rtl/diag_func_seq.sv
// Console-side diagnostic function sequencer: drives EBUS ds/diagStrobe/data with fixed
// setup/strobe/hold timing and captures read data. DIAG_FUNC_SEQ_PARITY_EN adds EBUS parity.
module diag_func_seq #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [0:6]  req_func,
    input  logic [35:0] req_wdata,
    output logic        rsp_valid,
    output logic [35:0] rsp_rdata,
    output logic [0:6]  ebus_ds,
    output logic        ebus_diag_strobe,
    output logic [35:0] ebus_data_out,
    output logic        ebus_drive,
    input  logic [35:0] ebus_data_in,
`ifdef DIAG_FUNC_SEQ_PARITY_EN
    output logic        ebus_parity_out,
    input  logic        ebus_parity_in,
    output logic        rsp_par_err,
`endif
    output logic        busy
);

    localparam logic [3:0] SetupLoad  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] StrobeLoad = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HoldLoad   = (HOLD_CYC == 0) ? 4'd0 : 4'(HOLD_CYC - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic       is_read_q;
    logic       enter_done;

    always_comb begin
        enter_done = 1'b0;
        if (cnt_q == 4'd0) begin
            if (state_q == StHold) enter_done = 1'b1;
            if (state_q == StStrobe && HOLD_CYC == 0) enter_done = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            cnt_q            <= 4'd0;
            is_read_q        <= 1'b0;
            req_ready        <= 1'b1;
            busy             <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            ebus_ds          <= '0;
            ebus_diag_strobe <= 1'b0;
            ebus_data_out    <= '0;
            ebus_drive       <= 1'b0;
`ifdef DIAG_FUNC_SEQ_PARITY_EN
            ebus_parity_out  <= 1'b0;
            rsp_par_err      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        state_q       <= StSetup;
                        cnt_q         <= SetupLoad;
                        is_read_q     <= req_func[0];
                        req_ready     <= 1'b0;
                        busy          <= 1'b1;
                        ebus_ds       <= req_func;
                        ebus_drive    <= ~req_func[0];
                        ebus_data_out <= req_func[0] ? 36'd0 : req_wdata;
                        if (!req_func[0]) rsp_rdata <= '0;
`ifdef DIAG_FUNC_SEQ_PARITY_EN
                        ebus_parity_out <= ~req_func[0] & ~^req_wdata;
                        rsp_par_err     <= 1'b0;
`endif
                    end
                end
                StSetup: begin
                    if (cnt_q == 4'd0) begin
                        state_q          <= StStrobe;
                        cnt_q            <= StrobeLoad;
                        ebus_diag_strobe <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StStrobe: begin
                    if (cnt_q == 4'd0) begin
                        ebus_diag_strobe <= 1'b0;
                        state_q          <= (HOLD_CYC == 0) ? StDone : StHold;
                        cnt_q            <= HoldLoad;
                        // Capture on the last strobe cycle, when the addressed board is settled.
                        if (is_read_q) begin
                            rsp_rdata <= ebus_data_in;
`ifdef DIAG_FUNC_SEQ_PARITY_EN
                            rsp_par_err <= ~^{ebus_data_in, ebus_parity_in};
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StHold: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    state_q   <= StIdle;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase

            if (enter_done) begin
                rsp_valid     <= 1'b1;
                ebus_ds       <= '0;
                ebus_drive    <= 1'b0;
                ebus_data_out <= '0;
`ifdef DIAG_FUNC_SEQ_PARITY_EN
                ebus_parity_out <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_diag_func_seq.sv
// Self-checking bench for diag_func_seq: per-cycle timing model plus a response scoreboard.
`timescale 1ns/1ps
module tb_diag_func_seq;

    localparam int AS = 2, AT = 4, AH = 2;
    localparam int BS = 2, BT = 1, BH = 0;
`ifdef DIAG_FUNC_SEQ_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, valid_a, valid_b;
    logic [0:6]  req_func;
    logic [35:0] req_wdata, ebus_data_in;
    logic        ready_a, rsp_valid_a, strobe_a, drive_a, busy_a, par_out_a, par_err_a;
    logic        ready_b, rsp_valid_b, strobe_b, drive_b, busy_b, par_out_b, par_err_b;
    logic [35:0] rdata_a, dout_a, rdata_b, dout_b;
    logic [0:6]  ds_a, ds_b;
`ifdef DIAG_FUNC_SEQ_PARITY_EN
    logic        ebus_parity_in;
`else
    assign par_out_a = 1'b0;
    assign par_err_a = 1'b0;
    assign par_out_b = 1'b0;
    assign par_err_b = 1'b0;
`endif

    diag_func_seq #(.SETUP_CYC(AS), .STROBE_CYC(AT), .HOLD_CYC(AH)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(valid_a), .req_ready(ready_a),
        .req_func(req_func), .req_wdata(req_wdata), .rsp_valid(rsp_valid_a),
        .rsp_rdata(rdata_a), .ebus_ds(ds_a), .ebus_diag_strobe(strobe_a),
        .ebus_data_out(dout_a), .ebus_drive(drive_a), .ebus_data_in(ebus_data_in),
`ifdef DIAG_FUNC_SEQ_PARITY_EN
        .ebus_parity_out(par_out_a), .ebus_parity_in(ebus_parity_in), .rsp_par_err(par_err_a),
`endif
        .busy(busy_a)
    );

    diag_func_seq #(.SETUP_CYC(BS), .STROBE_CYC(BT), .HOLD_CYC(BH)) dut_fast (
        .clk(clk), .reset_n(reset_n), .req_valid(valid_b), .req_ready(ready_b),
        .req_func(req_func), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b),
        .rsp_rdata(rdata_b), .ebus_ds(ds_b), .ebus_diag_strobe(strobe_b),
        .ebus_data_out(dout_b), .ebus_drive(drive_b), .ebus_data_in(ebus_data_in),
`ifdef DIAG_FUNC_SEQ_PARITY_EN
        .ebus_parity_out(par_out_b), .ebus_parity_in(ebus_parity_in), .rsp_par_err(par_err_b),
`endif
        .busy(busy_b)
    );

    typedef struct packed {
        logic [0:6]  ds;
        logic        strobe;
        logic        drive;
        logic [35:0] dout;
        logic        rsp_valid;
        logic        ready;
        logic        busy;
        logic        par_out;
    } obs_t;

    typedef struct packed {
        logic [35:0] rdata;
        logic        par_err;
    } exp_t;

    typedef struct {
        int          which;
        logic [0:6]  func;
        logic [35:0] wdata;
        logic [35:0] rdin;
        logic        par_ok;
    } vec_t;

    obs_t obs_a, obs_b;
    exp_t q_a[$], q_b[$];
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[6];

    always_comb begin
        obs_a = '{ds: ds_a, strobe: strobe_a, drive: drive_a, dout: dout_a,
                  rsp_valid: rsp_valid_a, ready: ready_a, busy: busy_a, par_out: par_out_a};
        obs_b = '{ds: ds_b, strobe: strobe_b, drive: drive_b, dout: dout_b,
                  rsp_valid: rsp_valid_b, ready: ready_b, busy: busy_b, par_out: par_out_b};
    end

    // Expected outputs k cycles after the accepting edge (k=0: idle).
    function automatic obs_t model(input int s, input int t, input int h, input int k,
                                   input logic [0:6] func, input logic [35:0] wdata);
        obs_t e;
        int   lat;
        logic active;
        lat       = s + t + h + 1;
        active    = (k >= 1) && (k <= s + t + h);
        e.ds      = active ? func : 7'd0;
        e.strobe  = (k >= s + 1) && (k <= s + t);
        e.drive   = active && !func[0];
        e.dout    = e.drive ? wdata : 36'd0;
        e.rsp_valid = (k == lat);
        e.ready   = (k == 0) || (k >= lat + 1);
        e.busy    = !e.ready;
        e.par_out = PAR && e.drive && ~^wdata;
        return e;
    endfunction

    task automatic check_obs(input int which, input int k, input logic [0:6] func,
                             input logic [35:0] wdata);
        obs_t got, want;
        if (which == 0) begin
            got  = obs_a;
            want = model(AS, AT, AH, k, func, wdata);
        end else begin
            got  = obs_b;
            want = model(BS, BT, BH, k, func, wdata);
        end
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cycle%0d_dut%0d: got %h want %h", k, which, got, want);
        end
    endtask

    task automatic sb_poll();
        exp_t e;
        if (rsp_valid_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL rsp_a_spurious: got rsp_valid=1 want 0");
            end else begin
                e = q_a.pop_front();
                if (rdata_a !== e.rdata || par_err_a !== e.par_err) begin
                    errors++;
                    $display("FAIL rsp_a_data: got %o/%b want %o/%b",
                             rdata_a, par_err_a, e.rdata, e.par_err);
                end
            end
        end
        if (rsp_valid_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL rsp_b_spurious: got rsp_valid=1 want 0");
            end else begin
                e = q_b.pop_front();
                if (rdata_b !== e.rdata || par_err_b !== e.par_err) begin
                    errors++;
                    $display("FAIL rsp_b_data: got %o/%b want %o/%b",
                             rdata_b, par_err_b, e.rdata, e.par_err);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sb_poll();
    endtask

    task automatic run_txn(input int which, input logic [0:6] func, input logic [35:0] wdata,
                           input logic [35:0] rdin, input logic par_ok, input bit keep_valid);
        int   s, t, h, lat;
        exp_t e;
        if (which == 0) begin
            s = AS; t = AT; h = AH;
        end else begin
            s = BS; t = BT; h = BH;
        end
        lat = s + t + h + 1;
        check_obs(which, 0, func, wdata);
        req_func  = func;
        req_wdata = wdata;
        ebus_data_in = '0;
`ifdef DIAG_FUNC_SEQ_PARITY_EN
        ebus_parity_in = par_ok ? ~^rdin : ^rdin;
`endif
        if (which == 0) valid_a = 1'b1;
        else valid_b = 1'b1;
        e.rdata   = func[0] ? rdin : 36'd0;
        e.par_err = PAR && func[0] && !par_ok;
        if (which == 0) q_a.push_back(e);
        else q_b.push_back(e);
        step();
        if (!keep_valid) begin
            valid_a = 1'b0;
            valid_b = 1'b0;
        end
        for (int k = 1; k <= lat + 1; k++) begin
            check_obs(which, k, func, wdata);
            if (k <= lat) begin
                // Inputs must be ignored once a sequence is running.
                if (keep_valid) begin
                    req_func  = 7'($urandom);
                    req_wdata = {4'h0, $urandom};
                end
                ebus_data_in = (k >= s + 1 && k <= s + t) ? rdin : 36'd0;
                step();
            end
        end
    endtask

    initial begin
        vecs[0] = '{0, 7'o076, 36'o000017000000, 36'o0, 1'b1};
        vecs[1] = '{0, 7'o100, 36'o0, 36'o123456765432, 1'b1};
        vecs[2] = '{0, 7'o070, 36'o777777777777, 36'o555555555555, 1'b1};
        vecs[3] = '{0, 7'o177, 36'o0, 36'o0, 1'b1};
        vecs[4] = '{1, 7'o001, 36'o000000000005, 36'o0, 1'b1};
        vecs[5] = '{1, 7'o177, 36'o0, 36'o400000000001, 1'b1};

        // Reset with req_valid held high.
        reset_n      = 1'b0;
        valid_a      = 1'b1;
        valid_b      = 1'b1;
        req_func     = 7'o100;
        req_wdata    = '0;
        ebus_data_in = '0;
`ifdef DIAG_FUNC_SEQ_PARITY_EN
        ebus_parity_in = 1'b0;
`endif
        repeat (3) step();
        check_obs(0, 0, 7'o0, 36'd0);
        check_obs(1, 0, 7'o0, 36'd0);
        checks++;
        if (rdata_a !== 36'd0 || par_err_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdata: got %o/%b want 0/0", rdata_a, par_err_a);
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        reset_n = 1'b1;
        step();
        check_obs(0, 0, 7'o0, 36'd0);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].which, vecs[i].func, vecs[i].wdata, vecs[i].rdin, vecs[i].par_ok, 1'b0);
        end

        // Back-to-back with req_valid held high: second accept only after DONE->IDLE.
        run_txn(0, 7'o105, 36'o0, 36'o012345670123, 1'b1, 1'b1);
        run_txn(0, 7'o077, 36'o707070707070, 36'o0, 1'b1, 1'b0);

`ifdef DIAG_FUNC_SEQ_PARITY_EN
        run_txn(0, 7'o101, 36'o0, 36'o111111111111, 1'b0, 1'b0);
        run_txn(0, 7'o101, 36'o0, 36'o111111111110, 1'b1, 1'b0);
        run_txn(0, 7'o002, 36'o000000000007, 36'o0, 1'b1, 1'b0);
`endif

        // Reset during STROBE aborts with no response.
        req_func     = 7'o100;
        ebus_data_in = 36'o777000777000;
        valid_a      = 1'b1;
        step();
        valid_a = 1'b0;
        repeat (3) step();
        checks++;
        if (strobe_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_strobe: got strobe=%b want 1", strobe_a);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_obs(0, 0, 7'o0, 36'd0);
        repeat (12) step();
        check_obs(0, 0, 7'o0, 36'd0);

        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL missing_rsp: got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
